// File: rtl/key_conditioner.sv
// Four-channel push-button conditioner: 2-flop synchronizer, per-key debounce FSM,
// and registered press/release/hold pulses.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [3:0] KEY,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_hold
);

  localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StUp, StDebDown, StDown, StDebUp} state_e;

  logic [3:0] sync1_q, sync2_q;

  // Idle level of the active-low buttons is 1, so reset fills the synchronizer with 1s.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_chan
    state_e           state_q, state_d;
    logic [DebW-1:0]  deb_q, deb_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             done_q, done_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             hold_evt_q, hold_evt_d;
    logic             raw_pressed;

    assign raw_pressed = ~sync2_q[i];

    always_comb begin
      state_d    = state_q;
      deb_d      = deb_q;
      hold_d     = hold_q;
      done_d     = done_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      hold_evt_d = 1'b0;
      unique case (state_q)
        StUp: begin
          if (raw_pressed) begin
            state_d = StDebDown;
            deb_d   = '0;
          end
        end
        StDebDown: begin
          if (!raw_pressed) begin
            state_d = StUp;
          end else if (deb_q == DebLast) begin
            state_d = StDown;
            press_d = 1'b1;
            hold_d  = '0;
            done_d  = 1'b0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        StDown: begin
          if (hold_q == HoldLast && !done_q) begin
            hold_evt_d = 1'b1;
            done_d     = 1'b1;
          end
          if (!raw_pressed) begin
            state_d = StDebUp;
            deb_d   = '0;
          end else if (hold_q != HoldLast) begin
            hold_d = hold_q + 1'b1;
          end
        end
        StDebUp: begin
          // A bounce back to pressed resumes DOWN with the hold progress intact.
          if (raw_pressed) begin
            state_d = StDown;
          end else if (deb_q == DebLast) begin
            state_d   = StUp;
            release_d = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: state_d = StUp;
      endcase
    end

    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        state_q    <= StUp;
        deb_q      <= '0;
        hold_q     <= '0;
        done_q     <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_evt_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        deb_q      <= deb_d;
        hold_q     <= hold_d;
        done_q     <= done_d;
        press_q    <= press_d;
        release_q  <= release_d;
        hold_evt_q <= hold_evt_d;
      end
    end

    assign key_level[i]   = (state_q == StDown) || (state_q == StDebUp);
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_hold[i]    = hold_evt_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: cycle-level reference model feeding a scoreboard queue,
// directed scenarios with latency/count checks, then randomized bouncing keys.
module tb_key_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned H = 10;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [3:0] KEY;
  logic [3:0] key_level, key_press, key_release, key_hold;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] exp_q[$];

  // Reference model: a key's accepted level flips once D+1 consecutive synchronized
  // samples disagree with it; hold fires after H cycles spent settled in the pressed level.
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  logic [3:0] m_lvl = 4'h0;
  int         m_run[4];
  int         m_hacc[4];
  bit         m_done[4];

  task automatic model_step();
    logic [3:0] p, r, h;
    bit raw, settled_down;
    p = '0; r = '0; h = '0;
    if (rst) begin
      m_s1 = 4'hF;
      m_s2 = 4'hF;
      m_lvl = 4'h0;
      for (int k = 0; k < 4; k++) begin
        m_run[k] = 0; m_hacc[k] = 0; m_done[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        raw = ~m_s2[k];
        settled_down = m_lvl[k] && (m_run[k] == 0);
        if (settled_down && !m_done[k] && m_hacc[k] == int'(H) - 1) begin
          h[k] = 1'b1;
          m_done[k] = 1;
        end
        if (raw != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == int'(D) + 1) begin
            m_lvl[k] = raw;
            m_run[k] = 0;
            if (raw) begin
              p[k] = 1'b1; m_hacc[k] = 0; m_done[k] = 0;
            end else begin
              r[k] = 1'b1;
            end
          end
        end else begin
          if (settled_down && m_hacc[k] < int'(H) - 1) m_hacc[k]++;
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = KEY;
    end
    exp_q.push_back({m_lvl, p, r, h});
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_run[k] = 0; m_hacc[k] = 0; m_done[k] = 0;
    end
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      model_step();
    end
  end

  // Monitor: every cycle the DUT presents a fresh output vector; compare with the model.
  initial begin
    logic [15:0] exp_v, act_v;
    forever begin
      @(negedge CLOCK_50);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {key_level, key_press, key_release, key_hold};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d actual=%h expected=%h (level,press,release,hold)",
                   cyc, act_v, exp_v);
        end
      end
    end
  end

  int n_press[4], n_rel[4], n_hold[4];
  logic [3:0] lvl_seen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_hold[k] = 0;
    end
    lvl_seen = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      for (int k = 0; k < 4; k++) begin
        n_press[k] += int'(key_press[k]);
        n_rel[k]   += int'(key_release[k]);
        n_hold[k]  += int'(key_hold[k]);
      end
      lvl_seen |= key_level;
    end
  endtask

  // Waits up to 30 cycles for key_press[k]; returns cycles since t0, or -1 on timeout.
  task automatic wait_press(input int k, input int t0, output int lat, output logic [3:0] seen);
    lat = -1;
    seen = '0;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      @(negedge CLOCK_50);
      if (key_press[k]) begin
        lat = cyc - t0;
        seen = key_press;
      end
    end
  endtask

  initial begin
    int t0, lat;
    int seg[4];
    logic [3:0] seen;
    rst = 1'b1;
    KEY = 4'hF;
    step(3);
    rst = 1'b0;
    step(2);

    // Press latency and hold timing on KEY[0].
    clear_counts();
    KEY[0] = 1'b0;
    t0 = cyc;
    wait_press(0, t0, lat, seen);
    check("press_latency_k0", lat, 7);
    check("level_after_press_k0", int'(key_level[0]), 1);
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      @(negedge CLOCK_50);
      if (key_hold[0]) lat = cyc - t0;
    end
    check("hold_latency_k0", lat, 10);
    KEY[0] = 1'b1;
    step(12);

    // Short glitch on KEY[1] is rejected.
    clear_counts();
    KEY[1] = 1'b0;
    step(3);
    KEY[1] = 1'b1;
    step(12);
    check("glitch_pulses_k1", n_press[1] + n_rel[1] + n_hold[1], 0);
    check("glitch_level_k1", int'(lvl_seen[1]), 0);

    // Release bounce on KEY[2] is rejected, real release accepted.
    KEY[2] = 1'b0;
    step(12);
    clear_counts();
    KEY[2] = 1'b1;
    step(2);
    KEY[2] = 1'b0;
    step(8);
    check("bounce_release_k2", n_rel[2], 0);
    check("bounce_press_k2", n_press[2], 0);
    check("bounce_level_k2", int'(key_level[2]), 1);
    clear_counts();
    KEY[2] = 1'b1;
    step(12);
    check("final_release_k2", n_rel[2], 1);
    check("final_level_k2", int'(key_level[2]), 0);

    // Simultaneous presses on KEY[0] and KEY[3].
    KEY[0] = 1'b0;
    KEY[3] = 1'b0;
    wait_press(0, cyc, lat, seen);
    check("simul_press_vec", int'(seen), 9);
    KEY = 4'hF;
    step(12);

    // Reset while KEY[1] is held down, then re-press after reset.
    KEY[1] = 1'b0;
    step(12);
    rst = 1'b1;
    step(1);
    check("reset_outputs", int'({key_level, key_press, key_release, key_hold}), 0);
    rst = 1'b0;
    t0 = cyc;
    wait_press(1, t0, lat, seen);
    check("press_latency_after_rst_k1", lat, 7);
    KEY[1] = 1'b1;
    step(12);

    // Long hold on KEY[3]: exactly one hold pulse.
    clear_counts();
    KEY[3] = 1'b0;
    step(40);
    KEY[3] = 1'b1;
    step(12);
    check("long_press_k3", n_press[3], 1);
    check("long_hold_k3", n_hold[3], 1);
    check("long_release_k3", n_rel[3], 1);
    check("long_level_k3", int'(key_level[3]), 0);

    // Randomized bouncing keys with occasional reset.
    for (int k = 0; k < 4; k++) seg[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (seg[k] == 0) begin
          KEY[k] = 1'($urandom_range(0, 1));
          seg[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(6, 30));
        end
        seg[k]--;
      end
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    KEY = 4'hF;
    step(15);

    @(negedge CLOCK_50);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
